// File: rtl/leb128_pkg.sv
// leb128_pkg
// Shared definitions for the unsigned-LEB128 packer and unpacker.
//   LEB_CONT_BIT    bit position of the continuation flag in each byte
//   LEB_PAYLOAD_W   payload bits carried per byte
//   leb_max_bytes() bytes needed to carry a value of the given width
//   leb_dec_state_t decoder states (accumulate / resync-skip)
package leb128_pkg;

  localparam int LEB_CONT_BIT  = 7;
  localparam int LEB_PAYLOAD_W = 7;

  typedef enum logic {
    LEB_ACC  = 1'b0,
    LEB_SKIP = 1'b1
  } leb_dec_state_t;

  function automatic int leb_max_bytes(input int width);
    return (width + LEB_PAYLOAD_W - 1) / LEB_PAYLOAD_W;
  endfunction

endpackage

// File: rtl/leb128_unpack_u32_if.sv
// leb128_unpack_u32_if
// Byte-in / word-out stream bundle for the LEB128 unpacker.
//   in_byte/in_valid/in_ready        byte stream toward the decoder
//   out_value/out_len/out_err/
//   out_valid/out_ready              decoded result stream from the decoder
// Modports: master = stream source/sink side, slave = decoder side.
interface leb128_unpack_u32_if #(
  parameter int DATA_W = 32
);

  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_value;
  logic [2:0]        out_len;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_value, out_len, out_err, out_valid
  );

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_value, out_len, out_err, out_valid
  );

endinterface

// File: rtl/leb128_unpack_u32.sv
// leb128_unpack_u32
// Streaming unsigned-LEB128 decoder: one byte per cycle in, one decoded word
// (value, byte count, error flag) out, 1 cycle after the terminal byte.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  leb128_unpack_u32_if.slave (byte stream in, result stream out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LEB_ACC  | accumulating payload groups, cnt = index of next byte 0..4
// LEB_SKIP | discarding the tail of an over-length encoding until bit7=0
module leb128_unpack_u32
  import leb128_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  leb128_unpack_u32_if.slave bus
);

  localparam int         MAX_BYTES = leb_max_bytes(DATA_W);
  localparam int         WIDE_W    = DATA_W + LEB_PAYLOAD_W;
  localparam logic [2:0] LAST_IDX  = 3'(MAX_BYTES - 1);

  leb_dec_state_t    state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [2:0]        out_len_q, out_len_d;
  logic              out_err_q, out_err_d;
  logic              out_valid_q, out_valid_d;

  logic [LEB_PAYLOAD_W-1:0] payload;
  logic                     cont;
  logic                     in_ready;
  logic                     accept;
  logic                     last;
  logic                     ovf;
  logic [5:0]               shamt;
  logic [WIDE_W-1:0]        wide;
  logic [DATA_W-1:0]        acc_sum;

  // SKIP always drains; otherwise a byte may only enter if the result slot
  // is free now or frees this cycle (combinational from out_ready).
  assign in_ready = (state_q == LEB_SKIP) | ~out_valid_q | bus.out_ready;

  always_comb begin
    payload = bus.in_byte[LEB_PAYLOAD_W-1:0];
    cont    = bus.in_byte[LEB_CONT_BIT];
    accept  = bus.in_valid & in_ready;
    shamt   = 6'(cnt_q) * 6'd7;
    // Shift into a widened vector so bits pushed past DATA_W stay visible
    // for the overflow test on the last group.
    wide    = WIDE_W'(payload) << shamt;
    acc_sum = acc_q | wide[DATA_W-1:0];
    last    = (cnt_q == LAST_IDX);
    ovf     = last & (|wide[WIDE_W-1:DATA_W]);

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_value_d = out_value_q;
    out_len_d   = out_len_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q & ~bus.out_ready;

    if (accept) begin
      case (state_q)
        LEB_ACC: begin
          if (!cont || last) begin
            out_valid_d = 1'b1;
            out_value_d = acc_sum;
            out_len_d   = cnt_q + 3'd1;
            out_err_d   = ovf | cont;
            acc_d       = '0;
            cnt_d       = '0;
            if (cont) state_d = LEB_SKIP;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 3'd1;
          end
        end
        LEB_SKIP: begin
          if (!cont) state_d = LEB_ACC;
        end
        default: state_d = LEB_ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LEB_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_value_q <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_value_q <= out_value_d;
      out_len_q   <= out_len_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_value = out_value_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_leb128_unpack_u32.sv
// tb_leb128_unpack_u32
// Bench for leb128_unpack_u32: directed vectors, backpressure, reset mid-value,
// back-to-back single bytes and a random stream with random out_ready.
module tb_leb128_unpack_u32;

  typedef struct packed {
    logic        err;
    logic [2:0]  len;
    logic [31:0] value;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  leb128_unpack_u32_if #(.DATA_W(32)) ifc ();

  leb128_unpack_u32 #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;
  bit rnd_ready_en = 1'b0;

  res_t       got_q[$];
  res_t       exp_q[$];
  logic [7:0] stim_q[$];

  always @(posedge clk) cyc_cnt++;

  always @(posedge clk) begin
    if (rnd_ready_en) begin
      #1;
      ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready)
      got_q.push_back(res_t'({ifc.out_err, ifc.out_len, ifc.out_value}));
  end

  // Reference decoder: sum payload groups arithmetically; a value ends at a
  // clear bit7 or at the 5th byte; error when the sum exceeds 32 bits or the
  // 5th byte still continues, in which case bytes up to the next clear bit7
  // are dropped.
  function automatic void build_expected();
    longint unsigned sum = 0;
    int              n   = 0;
    bit              skipping = 0;
    bit              e;
    exp_q.delete();
    foreach (stim_q[i]) begin
      if (skipping) begin
        if (!stim_q[i][7]) skipping = 0;
      end else begin
        sum += 64'(stim_q[i][6:0]) << (7 * n);
        n++;
        if (n == 5) begin
          e = (sum >= 64'h1_0000_0000) || stim_q[i][7];
          exp_q.push_back(res_t'({e, 3'(n), sum[31:0]}));
          if (stim_q[i][7]) skipping = 1;
          n = 0;
          sum = 0;
        end else if (!stim_q[i][7]) begin
          exp_q.push_back(res_t'({1'b0, 3'(n), sum[31:0]}));
          n = 0;
          sum = 0;
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int cyc = 0;
    ifc.in_byte  = b;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    while (!ifc.in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!ifc.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout byte=%h in_ready=%b required=1", b, ifc.in_ready);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_stim();
    foreach (stim_q[i]) send_byte(stim_q[i]);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", ifc.out_valid); end
    checks++; if (ifc.out_value !== 32'h0) begin failures++; $display("FAIL rst_out_value got=%h exp=0", ifc.out_value); end
    checks++; if (ifc.out_len !== 3'd0) begin failures++; $display("FAIL rst_out_len got=%0d exp=0", ifc.out_len); end
    checks++; if (ifc.out_err !== 1'b0) begin failures++; $display("FAIL rst_out_err got=%b exp=0", ifc.out_err); end
    checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", ifc.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    got_q.delete();
    send_byte(8'h7F);
    checks++; if (ifc.out_valid !== 1'b1) begin failures++; $display("FAIL single_latency_valid got=%b exp=1", ifc.out_valid); end
    checks++; if (ifc.out_value !== 32'h7F) begin failures++; $display("FAIL single_value got=%h exp=7f", ifc.out_value); end
    checks++; if (ifc.out_len !== 3'd1) begin failures++; $display("FAIL single_len got=%0d exp=1", ifc.out_len); end
    checks++; if (ifc.out_err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", ifc.out_err); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_known();
    logic [7:0] v0[] = '{8'hE5, 8'h8E, 8'h26};
    logic [7:0] v1[] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    logic [7:0] v2[] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10};
    logic [7:0] v3[] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h05};
    logic [7:0] v4[] = '{8'h80, 8'h00};
    logic [7:0] v5[] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
    for (int t = 0; t < 6; t++) begin
      stim_q.delete();
      exp_q.delete();
      case (t)
        0: begin foreach (v0[i]) stim_q.push_back(v0[i]); exp_q.push_back(res_t'({1'b0, 3'd3, 32'h0009_8765})); end
        1: begin foreach (v1[i]) stim_q.push_back(v1[i]); exp_q.push_back(res_t'({1'b0, 3'd5, 32'hFFFF_FFFF})); end
        2: begin foreach (v2[i]) stim_q.push_back(v2[i]); exp_q.push_back(res_t'({1'b1, 3'd5, 32'h0})); end
        3: begin
             foreach (v3[i]) stim_q.push_back(v3[i]);
             exp_q.push_back(res_t'({1'b1, 3'd5, 32'h0}));
             exp_q.push_back(res_t'({1'b0, 3'd1, 32'h5}));
           end
        4: begin foreach (v4[i]) stim_q.push_back(v4[i]); exp_q.push_back(res_t'({1'b0, 3'd2, 32'h0})); end
        default: begin foreach (v5[i]) stim_q.push_back(v5[i]); exp_q.push_back(res_t'({1'b1, 3'd5, 32'hFFFF_FFFF})); end
      endcase
      got_q.delete();
      send_stim();
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL known%0d_count got=%0d exp=%0d", t, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL known%0d_res%0d got err=%b len=%0d val=%h exp err=%b len=%0d val=%h", t, i,
                   got_q[i].err, got_q[i].len, got_q[i].value, exp_q[i].err, exp_q[i].len, exp_q[i].value);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    ifc.out_ready = 1'b0;
    send_byte(8'h7F);
    ifc.in_byte  = 8'h01;
    ifc.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (ifc.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_held got=%b exp=0", ifc.in_ready); end
      checks++; if (ifc.out_value !== 32'h7F || ifc.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_value_held got valid=%b val=%h exp valid=1 val=7f", ifc.out_valid, ifc.out_value);
      end
    end
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ifc.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_release got=%b exp=1", ifc.in_ready); end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    checks++; if (ifc.out_valid !== 1'b1 || ifc.out_value !== 32'h01 || ifc.out_len !== 3'd1) begin
      failures++; $display("FAIL bp_next_value got valid=%b val=%h len=%0d exp valid=1 val=1 len=1", ifc.out_valid, ifc.out_value, ifc.out_len);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== res_t'({1'b0, 3'd1, 32'h7F})) begin failures++; $display("FAIL bp_first got=%h exp len1 7f", got_q[0]); end
      checks++; if (got_q[1] !== res_t'({1'b0, 3'd1, 32'h01})) begin failures++; $display("FAIL bp_second got=%h exp len1 01", got_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    got_q.delete();
    send_byte(8'hE5);
    send_byte(8'h8E);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (ifc.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", ifc.out_valid); end
    send_byte(8'h05);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== res_t'({1'b0, 3'd1, 32'h05})) begin failures++; $display("FAIL rstmid_value got=%h exp len1 05", got_q[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int start;
    got_q.delete();
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom_range(0, 127)));
    build_expected();
    start = cyc_cnt;
    foreach (stim_q[i]) send_byte(stim_q[i]);
    checks++; if (cyc_cnt - start != 8) begin failures++; $display("FAIL b2b_cycles got=%0d exp=8", cyc_cnt - start); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_res%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  enc[$];
    logic [31:0] v;
    int          r;
    int          bad;
    got_q.delete();
    stim_q.delete();
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 15);
      enc.delete();
      if (r == 0) begin
        for (int k = 0; k < $urandom_range(5, 8); k++) enc.push_back(8'h80 | 8'($urandom_range(0, 127)));
        enc.push_back(8'($urandom_range(0, 127)));
      end else if (r == 1) begin
        for (int k = 0; k < 4; k++) enc.push_back(8'h80 | 8'($urandom_range(0, 127)));
        enc.push_back(8'($urandom_range(0, 127)));
      end else begin
        v = $urandom >> $urandom_range(0, 31);
        do begin
          enc.push_back({1'b0, v[6:0]});
          v = v >> 7;
          if (v != 0) enc[enc.size() - 1][7] = 1'b1;
        end while (v != 0);
        if ($urandom_range(0, 3) == 0 && enc.size() < 5) begin
          enc[enc.size() - 1][7] = 1'b1;
          enc.push_back(8'h00);
        end
      end
      foreach (enc[k]) stim_q.push_back(enc[k]);
    end
    stim_q.push_back(8'h00);
    build_expected();
    rnd_ready_en = 1'b1;
    foreach (stim_q[i]) send_byte(stim_q[i]);
    rnd_ready_en = 1'b0;
    @(posedge clk);
    #2;
    ifc.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        if (bad < 10) $display("FAIL rand_res%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        bad++;
      end
    end
  endtask

  initial begin
    ifc.in_byte   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_known();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
